// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus types: opcodes, master FSM states, strobe bundle.
// Used by the interrupt-acknowledge master and its opcode-fetch helper.
package z80_bus_pkg;

  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_4D = 8'h4D;
  localparam logic [7:0] OP_CB = 8'hCB;

  typedef enum logic [3:0] {
    IDLE,
    A_T1,
    A_T2,
    A_TW,
    A_T3,
    F1_T1,
    F1_T2,
    F1_T3,
    F2_T1,
    F2_T2,
    F2_T3
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_T1,
    PH_T2,
    PH_T3
  } fetch_ph_t;

  typedef struct packed {
    logic m1_n;
    logic iorq_n;
    logic rd_n;
  } bus_t;

endpackage

// File: rtl/z80_opfetch_seq.sv
// One three-T-state opcode fetch driving a fixed byte onto the bus.
// A start pulse in the cycle before T1 launches (or relaunches) it.
module z80_opfetch_seq
  import z80_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] op,
  output logic       m1_n,
  output logic       rd_n,
  output logic [7:0] dout,
  output logic       dout_en
);

  fetch_ph_t ph, ph_n;

  always_comb begin
    ph_n = ph;
    if (start) begin
      ph_n = PH_T1;
    end else begin
      unique case (ph)
        PH_T1:   ph_n = PH_T2;
        PH_T2:   ph_n = PH_T3;
        PH_T3:   ph_n = PH_IDLE;
        default: ph_n = PH_IDLE;
      endcase
    end
  end

  // Byte stays on the bus through T3 so it is latched on the strobe rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= PH_IDLE;
      m1_n    <= 1'b1;
      rd_n    <= 1'b1;
      dout    <= 8'h00;
      dout_en <= 1'b0;
    end else begin
      ph      <= ph_n;
      m1_n    <= !(ph_n == PH_T1 || ph_n == PH_T2);
      rd_n    <= (ph_n != PH_T2);
      dout_en <= (ph_n != PH_IDLE);
      if (start) begin
        dout <= op;
      end else if (ph_n == PH_IDLE) begin
        dout <= 8'h00;
      end
    end
  end

endmodule

// File: rtl/z80_int_ack_master.sv
// Host-side Z80 mode-2 interrupt acknowledge and RETI (ED 4D) emitter.
// All bus outputs come straight from flops updated with the next state.
module z80_int_ack_master
  import z80_bus_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        INT_n,
  input  logic        IEN,
  input  logic        SAMPLE,
  input  logic [7:0]  I_REG,
  input  logic        RETI_REQ,
  input  logic        WAIT_n,
  input  logic [7:0]  DI,
  output logic        M1_n,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic [7:0]  DO,
  output logic        DO_EN,
  output logic [15:0] VECTOR,
  output logic        VEC_VALID,
  output logic        RETI_DONE,
  output logic        BUSY
);

  localparam int WW = $clog2(WAIT_STATES + 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_STATES);

  state_t        state, state_n;
  logic          reti_pend;
  logic [WW-1:0] wcnt;
  bus_t          ack;
  logic          f_start;
  logic [7:0]    f_op;
  logic          f_m1_n;
  logic          f_rd_n;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (reti_pend || RETI_REQ) begin
          state_n = F1_T1;
        end else if (SAMPLE && IEN && !INT_n) begin
          state_n = A_T1;
        end
      end
      A_T1:  state_n = A_T2;
      A_T2:  state_n = A_TW;
      A_TW: begin
        if (wcnt == WMAX && WAIT_n) begin
          state_n = A_T3;
        end
      end
      A_T3:  state_n = IDLE;
      F1_T1: state_n = F1_T2;
      F1_T2: state_n = F1_T3;
      F1_T3: state_n = F2_T1;
      F2_T1: state_n = F2_T2;
      F2_T2: state_n = F2_T3;
      F2_T3: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign f_start = (state_n == F1_T1) || (state_n == F2_T1);
  assign f_op    = (state_n == F1_T1) ? OP_ED : OP_4D;

  // wcnt reads 1 in the first TW and saturates at WAIT_STATES
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      reti_pend <= 1'b0;
      wcnt      <= WW'(1);
      VECTOR    <= 16'h0000;
      ack       <= '{m1_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1};
      VEC_VALID <= 1'b0;
      RETI_DONE <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == F1_T1) begin
        reti_pend <= 1'b0;
      end else if (RETI_REQ) begin
        reti_pend <= 1'b1;
      end
      if (state != A_TW) begin
        wcnt <= WW'(1);
      end else if (wcnt != WMAX) begin
        wcnt <= wcnt + WW'(1);
      end
      if (state == A_TW && state_n == A_T3) begin
        VECTOR <= {I_REG, DI};
      end
      ack.m1_n   <= !(state_n == A_T1 || state_n == A_T2 || state_n == A_TW);
      ack.iorq_n <= (state_n != A_TW);
      ack.rd_n   <= 1'b1;
      VEC_VALID  <= (state_n == A_T3);
      RETI_DONE  <= (state_n == F2_T3);
      BUSY       <= (state_n != IDLE);
    end
  end

  z80_opfetch_seq u_fetch (
    .clk     (CLK),
    .rst_n   (RESET_n),
    .start   (f_start),
    .op      (f_op),
    .m1_n    (f_m1_n),
    .rd_n    (f_rd_n),
    .dout    (DO),
    .dout_en (DO_EN)
  );

  assign M1_n   = ack.m1_n & f_m1_n;
  assign IORQ_n = ack.iorq_n;
  assign RD_n   = ack.rd_n & f_rd_n;

endmodule

// File: tb/tb_z80_int_ack_master.sv
// Directed bench for z80_int_ack_master with a vector/RETI scoreboard.
// Cycle n is observed 1 time unit after the n-th rising edge.
module tb_z80_int_ack_master;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        INT_n, IEN, SAMPLE, RETI_REQ, WAIT_n;
  logic [7:0]  I_REG, DI;
  logic        M1_n, IORQ_n, RD_n, DO_EN;
  logic [7:0]  DO;
  logic [15:0] VECTOR;
  logic        VEC_VALID, RETI_DONE, BUSY;

  typedef struct {
    logic [15:0] vec;
    int          at;
  } vexp_t;

  vexp_t      vec_q[$];
  int         reti_q[$];
  logic [7:0] rd_bytes[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m1_cnt, iorq_cnt, rd_cnt, busy_cnt, vv_cnt, done_cnt;
  int s;

  z80_int_ack_master #(.WAIT_STATES(2)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .INT_n     (INT_n),
    .IEN       (IEN),
    .SAMPLE    (SAMPLE),
    .I_REG     (I_REG),
    .RETI_REQ  (RETI_REQ),
    .WAIT_n    (WAIT_n),
    .DI        (DI),
    .M1_n      (M1_n),
    .IORQ_n    (IORQ_n),
    .RD_n      (RD_n),
    .DO        (DO),
    .DO_EN     (DO_EN),
    .VECTOR    (VECTOR),
    .VEC_VALID (VEC_VALID),
    .RETI_DONE (RETI_DONE),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    m1_cnt = 0; iorq_cnt = 0; rd_cnt = 0;
    busy_cnt = 0; vv_cnt = 0; done_cnt = 0;
    rd_bytes.delete();
  endtask

  task automatic monitor();
    vexp_t e;
    int    t;
    if (!M1_n) m1_cnt++;
    if (!IORQ_n) iorq_cnt++;
    if (BUSY) busy_cnt++;
    if (!RD_n) begin
      rd_cnt++;
      rd_bytes.push_back(DO);
    end
    if (VEC_VALID) begin
      vv_cnt++;
      if (vec_q.size() == 0) begin
        chk("vec_unexpected", VEC_VALID, 0);
      end else begin
        e = vec_q.pop_front();
        chk("vec_value", VECTOR, e.vec);
        chk("vec_cycle", cyc, e.at);
      end
    end
    if (RETI_DONE) begin
      done_cnt++;
      if (reti_q.size() == 0) begin
        chk("reti_unexpected", RETI_DONE, 0);
      end else begin
        t = reti_q.pop_front();
        chk("reti_cycle", cyc, t);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    monitor();
  endtask

  initial begin
    RESET_n = 1'b0; INT_n = 1'b1; IEN = 1'b0; SAMPLE = 1'b0;
    I_REG = 8'h00; RETI_REQ = 1'b0; WAIT_n = 1'b1; DI = 8'h00;
    clr();

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_strobes", {M1_n, IORQ_n, RD_n}, 3'b111);
    chk("rst_do", {DO_EN, DO}, 9'h000);
    chk("rst_vector", VECTOR, 16'h0000);
    chk("rst_flags", {VEC_VALID, RETI_DONE, BUSY}, 3'b000);
    RESET_n = 1'b1;
    tick(); tick();

    // acknowledge, no extra waits
    clr();
    INT_n = 1'b0; IEN = 1'b1; SAMPLE = 1'b1; I_REG = 8'h12; DI = 8'h34;
    vec_q.push_back('{vec: 16'h1234, at: cyc + 5});
    tick();
    SAMPLE = 1'b0;
    chk("ack_t1", {M1_n, IORQ_n, RD_n, BUSY}, 4'b0111);
    INT_n = 1'b1;
    repeat (5) tick();
    chk("ack_idle_busy", BUSY, 0);
    chk("ack_iorq_cycles", iorq_cnt, 2);
    chk("ack_m1_cycles", m1_cnt, 4);
    chk("ack_rd_cycles", rd_cnt, 0);
    chk("ack_vv_count", vv_cnt, 1);
    chk("ack_vector", VECTOR, 16'h1234);

    // masked interrupt
    clr();
    INT_n = 1'b0; IEN = 1'b0; SAMPLE = 1'b1;
    repeat (10) tick();
    IEN = 1'b1; SAMPLE = 1'b0;
    repeat (10) tick();
    INT_n = 1'b1; IEN = 1'b1;
    chk("mask_busy", busy_cnt, 0);
    chk("mask_strobes", m1_cnt + iorq_cnt + rd_cnt, 0);
    chk("mask_vv", vv_cnt, 0);

    // RETI
    clr();
    RETI_REQ = 1'b1;
    reti_q.push_back(cyc + 6);
    tick();
    RETI_REQ = 1'b0;
    chk("reti_f1t1", {DO_EN, DO, M1_n, RD_n}, {1'b1, 8'hED, 2'b01});
    repeat (6) tick();
    chk("reti_rd_cycles", rd_cnt, 2);
    chk("reti_bytes", {rd_bytes[0], rd_bytes[1]}, 16'hED4D);
    chk("reti_iorq", iorq_cnt, 0);
    chk("reti_m1_cycles", m1_cnt, 4);
    chk("reti_done_count", done_cnt, 1);
    chk("reti_idle", {DO_EN, BUSY}, 2'b00);

    // collision: RETI and SAMPLE in the same IDLE cycle
    clr();
    RETI_REQ = 1'b1; INT_n = 1'b0; IEN = 1'b1; SAMPLE = 1'b1;
    I_REG = 8'hAB; DI = 8'hCD;
    reti_q.push_back(cyc + 6);
    tick();
    RETI_REQ = 1'b0; SAMPLE = 1'b0;
    chk("col1_reti_first", {DO_EN, IORQ_n}, 2'b11);
    repeat (6) tick();
    chk("col1_gap", BUSY, 0);
    SAMPLE = 1'b1;
    vec_q.push_back('{vec: 16'hABCD, at: cyc + 5});
    tick();
    SAMPLE = 1'b0; INT_n = 1'b1;
    chk("col1_ack_t1", {M1_n, DO_EN}, 2'b00);
    repeat (5) tick();
    chk("col1_iorq", iorq_cnt, 2);
    chk("col1_rd", rd_cnt, 2);

    // collision: RETI request during an acknowledge
    clr();
    s = cyc;
    INT_n = 1'b0; SAMPLE = 1'b1; I_REG = 8'h56; DI = 8'h78;
    vec_q.push_back('{vec: 16'h5678, at: s + 5});
    reti_q.push_back(s + 12);
    tick();
    SAMPLE = 1'b0; INT_n = 1'b1; RETI_REQ = 1'b1;
    tick();
    RETI_REQ = 1'b0;
    repeat (4) tick();
    chk("col2_gap", BUSY, 0);
    tick();
    chk("col2_reti_start", {DO_EN, DO}, {1'b1, 8'hED});
    repeat (6) tick();
    chk("col2_idle", BUSY, 0);

    // extra wait states: WAIT_n low through three final-TW cycles
    clr();
    s = cyc;
    INT_n = 1'b0; SAMPLE = 1'b1; I_REG = 8'h9A; DI = 8'h11;
    vec_q.push_back('{vec: 16'h9ABC, at: s + 8});
    tick();
    SAMPLE = 1'b0; INT_n = 1'b1;
    repeat (3) tick();
    WAIT_n = 1'b0; DI = 8'h22;
    tick();
    DI = 8'h33;
    tick();
    chk("wait_no_early_capture", VECTOR, 16'h5678);
    tick();
    WAIT_n = 1'b1; DI = 8'hBC;
    tick();
    DI = 8'h00;
    tick();
    chk("wait_iorq_cycles", iorq_cnt, 5);
    chk("wait_vv", vv_cnt, 1);

    // reset in the middle of a RETI fetch
    clr();
    tick();
    RETI_REQ = 1'b1;
    tick();
    RETI_REQ = 1'b0;
    tick();
    chk("rst_mid_f1t2", {RD_n, DO}, {1'b0, 8'hED});
    #2;
    RESET_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {M1_n, IORQ_n, RD_n}, 3'b111);
    chk("rst_mid_do", {DO_EN, DO, BUSY}, 10'h000);
    repeat (2) tick();
    RESET_n = 1'b1;
    clr();
    repeat (10) tick();
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_no_pend", busy_cnt, 0);

    chk("vec_queue_empty", vec_q.size(), 0);
    chk("reti_queue_empty", reti_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_int_ack_master.md
# z80_int_ack_master

CPU-side counterpart of the Z80 daisy-chain interrupt logic. It sits between a non-Z80 host core and the Z80-style peripheral bus. On request it runs the mode-2 interrupt-acknowledge cycle (M1_n+IORQ_n) and captures the vector byte. It also emits the two-byte RETI opcode-fetch sequence (ED 4D), which the peripherals decode to release the IEI/IEO chain.

## Interface
- WAIT_STATES, 2, automatic wait T-states in the acknowledge cycle (≥1)
- CLK  in  1  system clock; one T-state per cycle
- RESET_n  in  1  asynchronous, active-low reset
- INT_n  in  1  wired-OR interrupt line from the daisy chain
- IEN  in  1  host interrupt-enable (IFF1)
- SAMPLE  in  1  host instruction-boundary strobe; INT_n is evaluated only here
- I_REG  in  8  high byte of the mode-2 vector
- RETI_REQ  in  1  single-cycle pulse: host executed RETI
- WAIT_n  in  1  peripheral wait; low extends the last TW
- DI  in  8  bus data from the peripherals
- M1_n, IORQ_n, RD_n  out  1 each  Z80 bus strobes
- DO  out  8  opcode byte driven during RETI fetches
- DO_EN  out  1  DO is valid and must be driven onto the bus
- VECTOR  out  16  {I_REG, DI} captured at acknowledge
- VEC_VALID  out  1  single-cycle pulse: VECTOR updated
- RETI_DONE  out  1  single-cycle pulse: RETI sequence finished
- BUSY  out  1  FSM not in IDLE

## Operation
- Reset values:
  - M1_n, IORQ_n and RD_n are 1.
  - DO is 8'h00, DO_EN is 0, VECTOR is 16'h0000.
  - VEC_VALID, RETI_DONE and BUSY are 0.
  - RETI_PEND is 0 and the FSM is in IDLE.
- RETI_PEND latch:
  - Set by RETI_REQ in any state.
  - Cleared on entry to F1_T1.
  - One deep: a RETI_REQ while the latch is already set is absorbed.
- FSM states: IDLE, A_T1, A_T2, A_TW, A_T3, F1_T1, F1_T2, F1_T3, F2_T1, F2_T2, F2_T3.
- Transitions from IDLE (same-cycle priority order):
  - If RETI_PEND (or RETI_REQ this cycle), go to F1_T1.
  - Else if SAMPLE && IEN && !INT_n, go to A_T1.
  - Otherwise stay in IDLE.
- Acknowledge cycle:
  - Sequence: A_T1 → A_T2 → A_TW. A_TW is held with counter wcnt until WAIT_STATES have elapsed and WAIT_n=1; then A_T3 → IDLE.
  - M1_n is low in A_T1, A_T2 and A_TW.
  - IORQ_n is low in A_TW only.
  - RD_n stays 1.
  - DI is captured into VECTOR[7:0], and I_REG into VECTOR[15:8], on the clock edge that leaves A_TW.
  - VEC_VALID=1 during A_T3.
- RETI sequence (Fn_T1 → Fn_T2 → Fn_T3, for fetch 1 then fetch 2):
  - M1_n is low in T1 and T2. RD_n is low in T2 only.
  - DO_EN=1 for T1–T3. DO is 8'hED in F1 states and 8'h4D in F2 states.
  - DO is held through T3 so peripherals latch it on the rising edge of M1_n/RD_n.
  - IORQ_n stays 1.
  - RETI_DONE=1 during F2_T3, then go to IDLE.
- Other rules:
  - INT_n, SAMPLE and IEN are ignored outside IDLE. The host keeps INT_n pending until the next SAMPLE.
  - WAIT_n is ignored outside A_TW.
  - RESET_n low at any point forces all outputs to their reset values asynchronously. A partial cycle is abandoned, with no VEC_VALID and no RETI_DONE.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Acknowledge latency:
  - SAMPLE edge → A_T1 in the next cycle.
  - With WAIT_n=1, the cycle lasts 3+WAIT_STATES cycles (5 at the default).
  - VEC_VALID appears in cycle 3+WAIT_STATES after the SAMPLE edge.
- Each cycle with WAIT_n=0 in the final TW adds exactly one TW cycle.
- RETI: 6 cycles from F1_T1 to F2_T3. RETI_DONE is in the 6th cycle.
- Back-to-back operation: one IDLE cycle is mandatory between operations. BUSY=0 in that cycle.

## Structure
- Shared package z80_bus_pkg:
  - Opcode constants OP_ED=8'hED, OP_4D=8'h4D, OP_CB=8'hCB.
  - FSM state enum.
  - Strobe-bundle typedef (M1_n, IORQ_n, RD_n).
- One sub-module: z80_opfetch_seq.
  - Runs a single three-T-state opcode fetch of a given byte.
  - Instantiated once and started twice by the top FSM (ED, then 4D).
- The wait counter is $clog2(WAIT_STATES+1) bits wide and lives in the top module.

## Test plan
- Acknowledge:
  - Stimulus: INT_n=0, IEN=1, SAMPLE pulse, I_REG=8'h12, DI=8'h34, WAIT_n=1.
  - Response: IORQ_n low for exactly 2 cycles; VECTOR=16'h1234; VEC_VALID pulses 5 cycles after SAMPLE.
- Masked interrupt:
  - Stimulus: IEN=0 (or SAMPLE=0) with INT_n=0 for 20 cycles.
  - Response: BUSY stays 0, bus strobes stay high, no VEC_VALID.
- RETI:
  - Stimulus: RETI_REQ pulse.
  - Response: DO=ED with RD_n low for 1 cycle, then DO=4D with RD_n low for 1 cycle; RETI_DONE on cycle 6; IORQ_n never low.
- Collisions:
  - Stimulus 1: RETI_REQ and SAMPLE/INT_n=0 in the same IDLE cycle.
    - Response: RETI runs first. The ack starts at the next SAMPLE after the mandatory IDLE cycle.
  - Stimulus 2: RETI_REQ during an ack.
    - Response: RETI starts after one IDLE cycle.
- Wait states:
  - Stimulus: WAIT_n=0 for 3 cycles during A_TW, with WAIT_STATES=2.
  - Response: A_TW occupancy is 2+3 cycles; DI is sampled only on the exit edge.
- Reset mid-operation:
  - Stimulus: RESET_n low during F1_T2.
  - Response: strobes go high immediately, DO_EN=0, no RETI_DONE. After release, IDLE with RETI_PEND=0.
